// File: rtl/jtkcpu_memctrl.sv
// ---------------------------------------------------------------------------
// jtkcpu_memctrl
//
// Bus-side responder for the CPU controller's memory requests. Each 8- or
// 16-bit request from the microcode becomes one or two byte cycles on the
// 8-bit external bus. Data is big-endian: the high byte lives at addr and the
// low byte at addr+1.
//
// Parameters:
//    AW    address width in bits
//    TOUT  bus wait timeout in cen cycles (only with JTKCPU_BUSTIMEOUT_EN)
//
// Ports:
//    clk, rst        system clock, synchronous active-low reset
//    cen             clock enable, every register advances only when cen=1
//    halt            blocks acceptance of new requests
//    req, wrq, mem16 request strobe, 1=write/0=read, 1=16-bit/0=8-bit
//    addr, din       access address and write data (8-bit writes use din[7:0])
//    dout            read data, 8-bit reads return {8'h00, byte}
//    busy, done      transaction in flight, one-cen-cycle completion pulse
//    bus_err         timeout flag, constant 0 unless the timeout is built in
//    bus_addr        external byte address
//    bus_dout        external write byte
//    bus_din         external read byte
//    bus_cs, bus_we  external chip select and write enable
//    bus_ok          external ready, a byte completes on a cen edge with
//                    bus_cs=1 and bus_ok=1
//
// Optional feature macro: JTKCPU_BUSTIMEOUT_EN
//    When defined, a wait counter aborts a byte cycle stuck on bus_ok=0 for
//    TOUT cen cycles: the access ends with done=1, bus_err=1 and, for reads,
//    dout=16'hFFFF. Without it, waits are unbounded and bus_err is tied low.
// ---------------------------------------------------------------------------
module jtkcpu_memctrl #(
   parameter int AW   = 16,
   parameter int TOUT = 255
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          halt,
   input  logic          req,
   input  logic          wrq,
   input  logic          mem16,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   din,
   output logic [15:0]   dout,
   output logic          busy,
   output logic          done,
   output logic          bus_err,
   output logic [AW-1:0] bus_addr,
   output logic [7:0]    bus_dout,
   input  logic [7:0]    bus_din,
   output logic          bus_cs,
   output logic          bus_we,
   input  logic          bus_ok
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } state_t;

   state_t        st, st_nx;
   logic          lat_wrq, lat_wrq_nx;
   logic          lat_mem16, lat_mem16_nx;
   logic [7:0]    lat_lo, lat_lo_nx;
   logic [15:0]   dout_nx;
   logic          busy_nx, done_nx, cs_nx, we_nx;
   logic [AW-1:0] addr_nx;
   logic [7:0]    bdout_nx;

`ifdef JTKCPU_BUSTIMEOUT_EN
   localparam int CW = $clog2(TOUT + 1);
   logic [CW-1:0] wcnt, wcnt_nx;
   logic          err_q, err_nx;
   assign bus_err = err_q;
`else
   assign bus_err = 1'b0;
`endif

   // Next-state and next-output logic. Every register defaults to holding
   // its value, except done which is a pulse and falls back to 0. The low
   // byte of the write data is kept aside because din may change while the
   // high byte is still on the bus.
   always_comb begin
      st_nx        = st;
      lat_wrq_nx   = lat_wrq;
      lat_mem16_nx = lat_mem16;
      lat_lo_nx    = lat_lo;
      dout_nx      = dout;
      busy_nx      = busy;
      done_nx      = 1'b0;
      cs_nx        = bus_cs;
      we_nx        = bus_we;
      addr_nx      = bus_addr;
      bdout_nx     = bus_dout;
`ifdef JTKCPU_BUSTIMEOUT_EN
      wcnt_nx      = wcnt;
      err_nx       = err_q;
`endif
      case (st)
         IDLE: begin
            if (req && !halt) begin
               lat_wrq_nx   = wrq;
               lat_mem16_nx = mem16;
               lat_lo_nx    = din[7:0];
               busy_nx      = 1'b1;
               cs_nx        = 1'b1;
               we_nx        = wrq;
               addr_nx      = addr;
               bdout_nx     = mem16 ? din[15:8] : din[7:0];
               st_nx        = mem16 ? HI : LO;
`ifdef JTKCPU_BUSTIMEOUT_EN
               wcnt_nx      = '0;
               err_nx       = 1'b0;
`endif
            end
         end
         HI: begin
            if (bus_ok) begin
               if (!lat_wrq) dout_nx[15:8] = bus_din;
               addr_nx  = bus_addr + AW'(1);
               bdout_nx = lat_lo;
               st_nx    = LO;
`ifdef JTKCPU_BUSTIMEOUT_EN
               wcnt_nx  = '0;
`endif
            end
         end
         LO: begin
            if (bus_ok) begin
               if (!lat_wrq) begin
                  dout_nx[7:0] = bus_din;
                  if (!lat_mem16) dout_nx[15:8] = 8'h00;
               end
               cs_nx   = 1'b0;
               we_nx   = 1'b0;
               busy_nx = 1'b0;
               done_nx = 1'b1;
               st_nx   = IDLE;
            end
         end
         default: st_nx = IDLE;
      endcase
`ifdef JTKCPU_BUSTIMEOUT_EN
      // The wait that would bring the counter to TOUT ends the access
      // instead, so a stuck byte costs exactly TOUT waiting cen cycles.
      if ((st == HI || st == LO) && !bus_ok) begin
         if (wcnt == CW'(TOUT - 1)) begin
            if (!lat_wrq) dout_nx = 16'hFFFF;
            cs_nx   = 1'b0;
            we_nx   = 1'b0;
            busy_nx = 1'b0;
            done_nx = 1'b1;
            err_nx  = 1'b1;
            st_nx   = IDLE;
         end else begin
            wcnt_nx = wcnt + CW'(1);
         end
      end
`endif
   end

   // State register. Reset wins over cen so a dropped transaction never
   // produces a done pulse; with cen low everything holds.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st        <= IDLE;
         lat_wrq   <= 1'b0;
         lat_mem16 <= 1'b0;
         lat_lo    <= 8'h00;
         dout      <= 16'h0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         bus_cs    <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_dout  <= 8'h00;
`ifdef JTKCPU_BUSTIMEOUT_EN
         wcnt      <= '0;
         err_q     <= 1'b0;
`endif
      end else if (cen) begin
         st        <= st_nx;
         lat_wrq   <= lat_wrq_nx;
         lat_mem16 <= lat_mem16_nx;
         lat_lo    <= lat_lo_nx;
         dout      <= dout_nx;
         busy      <= busy_nx;
         done      <= done_nx;
         bus_cs    <= cs_nx;
         bus_we    <= we_nx;
         bus_addr  <= addr_nx;
         bus_dout  <= bdout_nx;
`ifdef JTKCPU_BUSTIMEOUT_EN
         wcnt      <= wcnt_nx;
         err_q     <= err_nx;
`endif
      end
   end

endmodule

// File: tb/tb_jtkcpu_memctrl.sv
// ---------------------------------------------------------------------------
// tb_jtkcpu_memctrl
//
// Self-checking bench for jtkcpu_memctrl in its default build. A table of
// directed cycles with hand-derived expectations covers reset, the basic
// access shapes, address wrap, reset mid-access, halt and cen hold. Hand
// sequences cover stalls with a toggling cen and back-to-back requests.
// Random traffic is then checked against a transaction-level model that
// turns every accepted request into a queue of byte cycles.
// ---------------------------------------------------------------------------
module tb_jtkcpu_memctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cen = 1'b0;
   logic        halt = 1'b0;
   logic        req = 1'b0;
   logic        wrq = 1'b0;
   logic        mem16 = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [15:0] din = 16'h0000;
   logic [15:0] dout;
   logic        busy, done, bus_err;
   logic [15:0] bus_addr;
   logic [7:0]  bus_dout;
   logic [7:0]  bus_din = 8'h00;
   logic        bus_cs, bus_we;
   logic        bus_ok = 1'b0;

   int checks = 0;
   int failures = 0;

   jtkcpu_memctrl dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .halt     (halt),
      .req      (req),
      .wrq      (wrq),
      .mem16    (mem16),
      .addr     (addr),
      .din      (din),
      .dout     (dout),
      .busy     (busy),
      .done     (done),
      .bus_err  (bus_err),
      .bus_addr (bus_addr),
      .bus_dout (bus_dout),
      .bus_din  (bus_din),
      .bus_cs   (bus_cs),
      .bus_we   (bus_we),
      .bus_ok   (bus_ok)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Reference model: a pending list of byte cycles per transaction
   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      bit          hi;
   } byte_t;

   byte_t       q[$];
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_wr = 1'b0;
   logic        m_mem16 = 1'b0;
   logic [15:0] m_dout = 16'h0000;
   logic [15:0] m_addr = 16'h0000;
   logic [7:0]  m_bdout = 8'h00;

   task automatic model_edge();
      byte_t e;
      if (!rst) begin
         q.delete();
         m_busy = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_mem16 = 1'b0;
         m_dout = 16'h0000; m_addr = 16'h0000; m_bdout = 8'h00;
      end else if (cen) begin
         m_done = 1'b0;
         if (m_busy) begin
            if (bus_ok) begin
               e = q.pop_front();
               if (!m_wr) begin
                  if (e.hi) m_dout[15:8] = bus_din;
                  else begin
                     m_dout[7:0] = bus_din;
                     if (!m_mem16) m_dout[15:8] = 8'h00;
                  end
               end
               if (q.size() == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end else begin
                  m_addr = q[0].a;
                  m_bdout = q[0].d;
               end
            end
         end else if (req && !halt) begin
            m_wr = wrq;
            m_mem16 = mem16;
            m_busy = 1'b1;
            if (mem16) begin
               e.a = addr;          e.d = din[15:8]; e.hi = 1'b1; q.push_back(e);
               e.a = addr + 16'd1;  e.d = din[7:0];  e.hi = 1'b0; q.push_back(e);
            end else begin
               e.a = addr;          e.d = din[7:0];  e.hi = 1'b0; q.push_back(e);
            end
            m_addr = q[0].a;
            m_bdout = q[0].d;
         end
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later
   task automatic applyStimulus(input logic r, input logic c, input logic h,
                                input logic rq, input logic w, input logic m16,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic [7:0] bd, input logic ok);
      rst = r; cen = c; halt = h; req = rq; wrq = w; mem16 = m16;
      addr = a; din = d; bus_din = bd; bus_ok = ok;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Compare every output at once; bus_err must stay low in this build
   task automatic checkOutput(input string name, input logic e_busy,
                              input logic e_done, input logic e_cs,
                              input logic e_we, input logic [15:0] e_addr,
                              input logic [7:0] e_bdout, input logic [15:0] e_dout);
      logic [44:0] act, exp;
      act = {busy, done, bus_cs, bus_we, bus_err, bus_addr, bus_dout, dout};
      exp = {e_busy, e_done, e_cs, e_we, 1'b0, e_addr, e_bdout, e_dout};
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got busy=%b done=%b cs=%b we=%b err=%b addr=%h bdout=%h dout=%h, want busy=%b done=%b cs=%b we=%b err=0 addr=%h bdout=%h dout=%h",
                  name, busy, done, bus_cs, bus_we, bus_err, bus_addr, bus_dout, dout,
                  e_busy, e_done, e_cs, e_we, e_addr, e_bdout, e_dout);
      end
   endtask

   typedef struct {
      string       name;
      logic        rst, cen, halt, req, wrq, mem16;
      logic [15:0] addr, din;
      logic [7:0]  bdin;
      logic        ok;
      logic        busy, done, cs, we;
      logic [15:0] baddr;
      logic [7:0]  bdout;
      logic [15:0] dout;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // name, rst cen halt req wrq m16, addr din bdin ok, busy done cs we, baddr bdout dout
      tbl.push_back('{"reset0",    1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h00,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000,8'h00,16'h0000});
      tbl.push_back('{"reset_nocen",1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000,16'h0000,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000,8'h00,16'h0000});
      tbl.push_back('{"idle",      1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000,8'h00,16'h0000});
      tbl.push_back('{"rd8_accept",1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 16'h1234,16'h0000,8'hA5,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'h1234,8'h00,16'h0000});
      tbl.push_back('{"rd8_done",  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h1234,16'h0000,8'hA5,1'b1, 1'b0,1'b1,1'b0,1'b0, 16'h1234,8'h00,16'h00A5});
      tbl.push_back('{"rd8_idle",  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h1234,8'h00,16'h00A5});
      tbl.push_back('{"wr16_hi",   1'b1,1'b1,1'b0,1'b1,1'b1,1'b1, 16'h2000,16'hBEEF,8'h00,1'b1, 1'b1,1'b0,1'b1,1'b1, 16'h2000,8'hBE,16'h00A5});
      tbl.push_back('{"wr16_lo",   1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h77,1'b1, 1'b1,1'b0,1'b1,1'b1, 16'h2001,8'hEF,16'h00A5});
      tbl.push_back('{"wr16_done", 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h77,1'b1, 1'b0,1'b1,1'b0,1'b0, 16'h2001,8'hEF,16'h00A5});
      tbl.push_back('{"wr16_idle", 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h2001,8'hEF,16'h00A5});
      tbl.push_back('{"rd16_acc",  1'b1,1'b1,1'b0,1'b1,1'b0,1'b1, 16'hFFFF,16'h0000,8'h12,1'b0, 1'b1,1'b0,1'b1,1'b0, 16'hFFFF,8'h00,16'h00A5});
      tbl.push_back('{"rd16_wrap", 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h12,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'h0000,8'h00,16'h12A5});
      tbl.push_back('{"rd16_done", 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h34,1'b1, 1'b0,1'b1,1'b0,1'b0, 16'h0000,8'h00,16'h1234});
      tbl.push_back('{"b2b_acc",   1'b1,1'b1,1'b0,1'b1,1'b0,1'b1, 16'h4000,16'h0000,8'h56,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'h4000,8'h00,16'h1234});
      tbl.push_back('{"rst_lo",    1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h56,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'h4001,8'h00,16'h5634});
      tbl.push_back('{"rst_drop",  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h78,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000,8'h00,16'h0000});
      tbl.push_back('{"rst_nodone",1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h78,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000,8'h00,16'h0000});
      tbl.push_back('{"halt_blk",  1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 16'h0055,16'h00C3,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000,8'h00,16'h0000});
      tbl.push_back('{"halt_blk2", 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 16'h0055,16'h00C3,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000,8'h00,16'h0000});
      tbl.push_back('{"halt_rel",  1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 16'h0055,16'h00C3,8'h00,1'b1, 1'b1,1'b0,1'b1,1'b1, 16'h0055,8'hC3,16'h0000});
      tbl.push_back('{"wr8_done",  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h00,1'b1, 1'b0,1'b1,1'b0,1'b0, 16'h0055,8'hC3,16'h0000});
      tbl.push_back('{"cen_hold",  1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h1111,16'h0000,8'h00,1'b1, 1'b0,1'b1,1'b0,1'b0, 16'h0055,8'hC3,16'h0000});
      tbl.push_back('{"done_clr",  1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000,16'h0000,8'h00,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0055,8'hC3,16'h0000});

      $display("[TB] directed table, %0d rows", tbl.size());
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].rst, tbl[i].cen, tbl[i].halt, tbl[i].req, tbl[i].wrq,
                       tbl[i].mem16, tbl[i].addr, tbl[i].din, tbl[i].bdin, tbl[i].ok);
         checkOutput(tbl[i].name, tbl[i].busy, tbl[i].done, tbl[i].cs, tbl[i].we,
                     tbl[i].baddr, tbl[i].bdout, tbl[i].dout);
      end

      // Stall in HI with cen toggling: three waiting cen edges, then ready
      $display("[TB] stall sequence");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3000, 16'h0000, 8'h9A, 1'b0);
      checkOutput("stall_acc", 1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 8'h00, 16'h0000);
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, (k % 2 == 0), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h9A, 1'b0);
         checkOutput("stall_wait", 1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 8'h00, 16'h0000);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h9A, 1'b1);
      checkOutput("stall_cen0", 1'b1, 1'b0, 1'b1, 1'b0, 16'h3000, 8'h00, 16'h0000);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h9A, 1'b1);
      checkOutput("stall_hi", 1'b1, 1'b0, 1'b1, 1'b0, 16'h3001, 8'h00, 16'h9A00);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'hBC, 1'b1);
      checkOutput("stall_done", 1'b0, 1'b1, 1'b0, 1'b0, 16'h3001, 8'h00, 16'h9ABC);

      // Back-to-back: a held req is ignored while busy, taken while done=1
      $display("[TB] back-to-back sequence");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0011, 8'h00, 1'b1);
      checkOutput("b2b_a", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 8'h11, 16'h9ABC);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0022, 8'h00, 1'b1);
      checkOutput("b2b_a_done", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h11, 16'h9ABC);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0022, 8'h00, 1'b1);
      checkOutput("b2b_b", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0020, 8'h22, 16'h9ABC);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'h00, 1'b1);
      checkOutput("b2b_b_done", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0020, 8'h22, 16'h9ABC);

      // Random traffic against the transaction-level model
      $display("[TB] random traffic");
      for (int n = 0; n < 1500; n++) begin
         logic [15:0] ra;
         ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1),
                       ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                       ra, 16'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));
         checkOutput("rand", m_busy, m_done, m_busy, m_busy && m_wr, m_addr, m_bdout, m_dout);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
